// File: rtl/sm_dco_integrator.sv
// Sign-magnitude phase-error integrator feeding the ADPLL DCO with an offset-binary control word.
// Optional build macro SM_DCO_LEAK_EN turns the pure integrator into a leaky one (shift LEAK_SH).

module sm_dco_integrator #(
    parameter int MAG_W   = 5,
    parameter int ACC_W   = 8
`ifdef SM_DCO_LEAK_EN
    ,
    parameter int LEAK_SH = 3
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [MAG_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] dco_word,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The sender holds its payload until that edge; ready never depends on the same-side valid.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV    = 2'd1,
        ACCUM   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t state_q;
    state_t state_d;

    logic                    sign_q;
    logic        [MAG_W-1:0] mag_q;
    logic signed [ACC_W:0]   conv_q;
    logic        [ACC_W-1:0] acc_q;
    logic                    sat_hi_q;
    logic                    sat_lo_q;

    logic signed [ACC_W:0]   mag_ext;
    logic signed [ACC_W:0]   conv_c;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   sum_c;
    logic        [ACC_W-1:0] acc_d;
    logic                    sat_hi_d;
    logic                    sat_lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Negative zero falls out naturally: negating a zero magnitude is still zero.
    always_comb begin
        mag_ext = {{(ACC_W+1-MAG_W){1'b0}}, mag_q};
        conv_c  = sign_q ? -mag_ext : mag_ext;
    end

    always_comb begin
        acc_ext = {acc_q[ACC_W-1], acc_q};
`ifdef SM_DCO_LEAK_EN
        sum_c = acc_ext - (acc_ext >>> LEAK_SH) + conv_q;
`else
        sum_c = acc_ext + conv_q;
`endif
        acc_d    = sum_c[ACC_W-1:0];
        sat_hi_d = 1'b0;
        sat_lo_d = 1'b0;
        if (sum_c > ACC_MAX) begin
            acc_d    = ACC_MAX[ACC_W-1:0];
            sat_hi_d = 1'b1;
        end else if (sum_c < ACC_MIN) begin
            acc_d    = ACC_MIN[ACC_W-1:0];
            sat_lo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            mag_q    <= '0;
            conv_q   <= '0;
            acc_q    <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        mag_q  <= in_mag;
                    end
                end
                CONV: begin
                    conv_q <= conv_c;
                end
                ACCUM: begin
                    acc_q    <= acc_d;
                    sat_hi_q <= sat_hi_d;
                    sat_lo_q <= sat_lo_d;
                end
                default: begin
                end
            endcase
        end
    end

    // Offset binary is two's complement with the sign bit inverted.
    assign dco_word  = {~acc_q[ACC_W-1], acc_q[ACC_W-2:0]};
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sm_dco_integrator.sv
// Self-checking bench for sm_dco_integrator: directed scenarios plus randomized traffic
// checked every cycle against an arithmetic integrator model.

`timescale 1ns/1ps

module tb_sm_dco_integrator;

    localparam int MAG_W = 5;
    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [MAG_W-1:0] in_mag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] dco_word;
    logic             sat_hi;
    logic             sat_lo;
    logic [1:0]       state_dbg;

    int checks   = 0;
    int failures = 0;
    int acc_m    = 0;
    logic [9:0] exp_q[$];   // {sat_hi, sat_lo, dco_word}
    bit rand_phase = 1'b0;

    sm_dco_integrator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dco_word  (dco_word),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        acc_m = 0;
        rst   = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic void model_word(input logic s, input logic [MAG_W-1:0] m);
        int conv;
        int sum;
        logic hi;
        logic lo;
        conv = s ? -int'(m) : int'(m);
`ifdef SM_DCO_LEAK_EN
        sum = acc_m - (acc_m >>> 3) + conv;
`else
        sum = acc_m + conv;
`endif
        hi = 1'b0;
        lo = 1'b0;
        if (sum > 127) begin
            acc_m = 127;
            hi    = 1'b1;
        end else if (sum < -128) begin
            acc_m = -128;
            lo    = 1'b1;
        end else begin
            acc_m = sum;
        end
        exp_q.push_back({hi, lo, 8'(acc_m + 128)});
    endfunction

    // ---------------- drivers ----------------
    task automatic send_word(input logic s, input logic [MAG_W-1:0] m);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sign  = s;
        in_mag   = m;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                model_word(s, m);
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_mag   = MAG_W'($urandom);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL out_timeout actual=no_valid required=valid");
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("hs_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=0x%0h required=none", dco_word);
                end else begin
                    check("sb_dco", {24'd0, dco_word}, {24'd0, exp_q[0][7:0]});
                    check("sb_sat_hi", {31'd0, sat_hi}, {31'd0, exp_q[0][9]});
                    check("sb_sat_lo", {31'd0, sat_lo}, {31'd0, exp_q[0][8]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        do_reset();
        @(negedge clk);
        check("rst_dco", {24'd0, dco_word}, 32'h80);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
        @(posedge clk);
        #1;

        // latency and basic arithmetic
        out_ready = 1'b1;
        send_word(1'b0, 5'd5);
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_cycle3", {31'd0, out_valid}, 32'd1);
        check("plus5_dco", {24'd0, dco_word}, 32'h85);
        send_word(1'b1, 5'd12);
        wait_valid();
        check("minus12_dco", {24'd0, dco_word}, 32'h79);
        @(posedge clk); #1;

        // negative zero
        do_reset();
        send_word(1'b1, 5'd0);
        wait_valid();
        check("negzero_dco", {24'd0, dco_word}, 32'h80);
        check("negzero_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
        @(posedge clk); #1;

        // positive and negative saturation
        do_reset();
        repeat (5) send_word(1'b0, 5'd31);
        wait_valid();
`ifndef SM_DCO_LEAK_EN
        check("sat_hi_dco", {24'd0, dco_word}, 32'hFF);
        check("sat_hi_flag", {31'd0, sat_hi}, 32'd1);
`endif
        @(posedge clk); #1;
        do_reset();
        repeat (5) send_word(1'b1, 5'd31);
        wait_valid();
`ifndef SM_DCO_LEAK_EN
        check("sat_lo_dco", {24'd0, dco_word}, 32'h00);
        check("sat_lo_flag", {31'd0, sat_lo}, 32'd1);
`endif
        @(posedge clk); #1;

        // backpressure hold with a competing input word
        do_reset();
        out_ready = 1'b0;
        send_word(1'b0, 5'd3);
        wait_valid();
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_mag   = 5'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_dco", {24'd0, dco_word}, 32'h83);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(1'b0, 5'd7);
        wait_valid();
        check("after_hold_dco", {24'd0, dco_word}, 32'h8A);
        @(posedge clk); #1;

        // reset while in ACCUM
        do_reset();
        send_word(1'b0, 5'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        acc_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_dco", {24'd0, dco_word}, 32'h80);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

`ifdef SM_DCO_LEAK_EN
        // leak: 31 -> 59 -> 64, then zero inputs decay 64 -> 56 -> 49
        do_reset();
        send_word(1'b0, 5'd31);
        send_word(1'b0, 5'd31);
        send_word(1'b0, 5'd12);
        wait_valid();
        check("leak_preload", {24'd0, dco_word}, 32'hC0);
        send_word(1'b0, 5'd0);
        wait_valid();
        check("leak_step1", {24'd0, dco_word}, 32'hB8);
        send_word(1'b0, 5'd0);
        wait_valid();
        check("leak_step2", {24'd0, dco_word}, 32'hB1);
        @(posedge clk); #1;
`endif

        // randomized traffic with random backpressure
        do_reset();
        rand_phase = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic             s;
            logic [MAG_W-1:0] m;
            s = 1'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 5'd31 : MAG_W'($urandom);
            send_word(s, m);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_phase = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
